// File: rtl/rmt_ctrl_pkg.sv
// Shared constants for the RMT control-plane writers: control-packet match
// values, header field positions and the parse-action writer state encoding.
package rmt_ctrl_pkg;

    localparam logic [15:0] CTRL_PORT = 16'hF1F2;
    localparam logic [7:0]  MOD_ID    = 8'h00;

    // Header fields on beat 0 of a 256b control-stream packet
    localparam int PORT_LO  = 128;
    localparam int PORT_HI  = 143;
    localparam int MODID_LO = 192;
    localparam int MODID_HI = 199;
    localparam int ADDR_LO  = 208;
    localparam int ADDR_HI  = 211;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_CFG_D1 = 3'd2,
        ST_CFG_D2 = 3'd3,
        ST_CFG_WR = 3'd4,
        ST_DROP   = 3'd5
    } cfg_state_e;

    // Saturating increment for the 16-bit status counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/parse_act_cfg_ctrl.sv
// Parse-action RAM writer on the control stream. Packets addressed to this
// module (UDP dst port + module ID) are consumed and turned into one port-A
// RAM write each; every other packet passes through untouched.
//
// Handshake: a beat transfers on a cycle where valid && ready are both high.
// A source holds data/last stable while valid is high and not yet accepted;
// ready may depend combinationally on valid-side data (the header match).
module parse_act_cfg_ctrl
    import rmt_ctrl_pkg::*;
#(
    parameter int          C_AXIS_DATA_WIDTH  = 256,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter int          C_RAM_DATA_WIDTH   = 260,
    parameter int          C_RAM_ADDR_WIDTH   = 4,
    parameter logic [15:0] C_CTRL_PORT        = CTRL_PORT,
    parameter logic [7:0]  C_MOD_ID           = MOD_ID
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [C_RAM_ADDR_WIDTH-1:0]     ram_addra,
    output logic [C_RAM_DATA_WIDTH-1:0]     ram_dina,
    output logic                            ram_ena,
    output logic                            ram_wea,
    output logic [15:0]                     cfg_wr_cnt,
    output logic [15:0]                     cfg_err_cnt,
    output logic [2:0]                      state_dbg
);

    localparam int ENTRY_HI_W = C_RAM_DATA_WIDTH - C_AXIS_DATA_WIDTH;

    cfg_state_e                   state;
    logic [C_RAM_ADDR_WIDTH-1:0]  addr_q;
    logic [C_AXIS_DATA_WIDTH-1:0] entry_q;
    logic                         hit;
    logic                         s_rdy;
    logic                         m_vld;
    logic                         s_hs;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;

    assign hit = (s_axis_tdata[PORT_HI:PORT_LO] == C_CTRL_PORT) &&
                 (s_axis_tdata[MODID_HI:MODID_LO] == C_MOD_ID);

    // Ready/valid steering per state; config beats are never backpressured
    always_comb begin
        s_rdy = 1'b0;
        m_vld = 1'b0;
        unique case (state)
            ST_IDLE: begin
                s_rdy = hit ? 1'b1 : m_axis_tready;
                m_vld = s_axis_tvalid & ~hit;
            end
            ST_FWD: begin
                s_rdy = m_axis_tready;
                m_vld = s_axis_tvalid;
            end
            ST_CFG_D1, ST_CFG_D2, ST_DROP: s_rdy = 1'b1;
            default: ;
        endcase
    end

    // Both handshake outputs are held low while reset is asserted
    assign s_axis_tready = s_rdy & aresetn;
    assign m_axis_tvalid = m_vld & aresetn;
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign state_dbg     = state;

    // Packet FSM, entry latches, registered RAM write port and counters
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            entry_q     <= '0;
            ram_addra   <= '0;
            ram_dina    <= '0;
            ram_ena     <= 1'b0;
            ram_wea     <= 1'b0;
            cfg_wr_cnt  <= '0;
            cfg_err_cnt <= '0;
        end else begin
            ram_ena <= 1'b0;
            ram_wea <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        if (!hit) begin
                            if (!s_axis_tlast) state <= ST_FWD;
                        end else if (!s_axis_tlast) begin
                            addr_q <= s_axis_tdata[ADDR_LO +: C_RAM_ADDR_WIDTH];
                            state  <= ST_CFG_D1;
                        end else begin
                            cfg_err_cnt <= sat_inc(cfg_err_cnt);
                        end
                    end
                end
                ST_FWD: begin
                    if (s_hs && s_axis_tlast) state <= ST_IDLE;
                end
                ST_CFG_D1: begin
                    if (s_hs) begin
                        entry_q <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            cfg_err_cnt <= sat_inc(cfg_err_cnt);
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_CFG_D2;
                        end
                    end
                end
                ST_CFG_D2: begin
                    if (s_hs) begin
                        if (s_axis_tlast) begin
                            // Write strobe lands in CFG_WR, one cycle after this beat
                            ram_addra <= addr_q;
                            ram_dina  <= {s_axis_tdata[ENTRY_HI_W-1:0], entry_q};
                            ram_ena   <= 1'b1;
                            ram_wea   <= 1'b1;
                            state     <= ST_CFG_WR;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_CFG_WR: begin
                    cfg_wr_cnt <= sat_inc(cfg_wr_cnt);
                    state      <= ST_IDLE;
                end
                ST_DROP: begin
                    if (s_hs && s_axis_tlast) begin
                        cfg_err_cnt <= sat_inc(cfg_err_cnt);
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parse_act_cfg_ctrl.sv
// Directed bench for parse_act_cfg_ctrl: config writes, passthrough with
// backpressure, malformed packets, back-to-back writes and mid-packet reset.
module tb_parse_act_cfg_ctrl;
    import rmt_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [255:0] s_axis_tdata = '0;
    logic [31:0]  s_axis_tkeep = 32'hFFFF_FFFF;
    logic [127:0] s_axis_tuser = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic [3:0]   ram_addra;
    logic [259:0] ram_dina;
    logic         ram_ena;
    logic         ram_wea;
    logic [15:0]  cfg_wr_cnt;
    logic [15:0]  cfg_err_cnt;
    logic [2:0]   state_dbg;

    parse_act_cfg_ctrl dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .ram_addra     (ram_addra),
        .ram_dina      (ram_dina),
        .ram_ena       (ram_ena),
        .ram_wea       (ram_wea),
        .cfg_wr_cnt    (cfg_wr_cnt),
        .cfg_err_cnt   (cfg_err_cnt),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           failures = 0;
    logic [256:0] exp_q[$];
    logic [256:0] fwd_e;
    logic [259:0] mem [16];
    int           wr_pulses = 0;
    int           wr_cyc_q[$];
    int           last_hs_cyc = 0;
    int           stall_cycles = 0;
    logic         toggle_en = 1'b0;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Downstream toggling backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (toggle_en) m_axis_tready = ~m_axis_tready;
    end

    // Monitor at the falling edge: forwarded beats and RAM writes
    always @(negedge clk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fwd_valid", {263'h0, m_axis_tvalid}, 264'h0);
                end else begin
                    fwd_e = exp_q.pop_front();
                    check("fwd_beat", {7'h0, m_axis_tlast, m_axis_tdata}, {7'h0, fwd_e});
                    check("fwd_keep", {232'h0, m_axis_tkeep}, {232'h0, 32'hFFFF_FFFF});
                    check("fwd_user", {136'h0, m_axis_tuser},
                          {136'h0, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978});
                end
            end
            if (ram_ena && ram_wea) begin
                mem[ram_addra] = ram_dina;
                wr_pulses++;
                wr_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [255:0] make_hdr(input logic [15:0] port, input logic [7:0] modid,
                                              input logic [3:0] addr);
        logic [255:0] h;
        h = {8{32'h1357_9BDF}};
        h[PORT_HI:PORT_LO]   = port;
        h[MODID_HI:MODID_LO] = modid;
        h[ADDR_HI:ADDR_LO]   = addr;
        return h;
    endfunction

    task automatic drive_beat(input logic [255:0] d, input logic last);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 50) begin
            stall_cycles++;
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) check("beat_accept_timeout", {263'h0, s_axis_tready}, 264'h1);
        last_hs_cyc = cyc;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_cfg(input logic [3:0] addr, input logic [255:0] d1, input logic [3:0] nib);
        drive_beat(make_hdr(CTRL_PORT, MOD_ID, addr), 1'b0);
        drive_beat(d1, 1'b0);
        drive_beat({252'hBAD_F00D, nib}, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    logic [255:0] a5;
    logic [255:0] e1;
    logic [255:0] e2;
    logic [255:0] fb [4];
    int           wr_before;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        a5 = {32{8'hA5}};
        e1 = {8{32'h1111_2222}};
        e2 = {8{32'h3333_4444}};

        // Reset state
        #1;
        check("rst_tready", {263'h0, s_axis_tready}, 264'h0);
        check("rst_state", {261'h0, state_dbg}, 264'h0);
        check("rst_ena", {262'h0, ram_ena, ram_wea}, 264'h0);
        check("rst_cnts", {232'h0, cfg_wr_cnt, cfg_err_cnt}, 264'h0);
        idle_cycles(3);
        aresetn = 1'b1;
        idle_cycles(2);

        // 1: config packet, addr 5
        send_cfg(4'h5, a5, 4'hC);
        idle_cycles(3);
        check("t1_pulses", wr_pulses, 1);
        check("t1_mem5", {4'h0, mem[5]}, {4'h0, 4'hC, a5});
        check("t1_addra", {260'h0, ram_addra}, {260'h0, 4'h5});
        if (wr_cyc_q.size() == 1) check("t1_latency", wr_cyc_q[0], last_hs_cyc + 1);
        else check("t1_wr_hist", wr_cyc_q.size(), 1);
        check("t1_wr_cnt", {248'h0, cfg_wr_cnt}, {248'h0, 16'd1});
        check("t1_err_cnt", {248'h0, cfg_err_cnt}, 264'h0);
        check("t1_ena_low", {262'h0, ram_ena, ram_wea}, 264'h0);

        // 2: non-hit 4-beat packet with toggling downstream ready
        fb[0] = make_hdr(16'h0800, MOD_ID, 4'h5);
        fb[1] = {8{32'hCAFE_0001}};
        fb[2] = {8{32'hCAFE_0002}};
        fb[3] = {8{32'hCAFE_0003}};
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, fb[i]});
        toggle_en = 1'b1;
        for (int i = 0; i < 4; i++) drive_beat(fb[i], (i == 3) ? 1'b1 : 1'b0);
        toggle_en = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;
        idle_cycles(2);
        check("t2_all_fwd", exp_q.size(), 0);
        check("t2_no_write", wr_pulses, 1);
        check("t2_cnts", {232'h0, cfg_wr_cnt, cfg_err_cnt}, {232'h0, 16'd1, 16'd0});
        check("t2_addra_hold", {260'h0, ram_addra}, {260'h0, 4'h5});
        check("t2_dina_hold", {4'h0, ram_dina}, {4'h0, 4'hC, a5});

        // 3: hit packet ending on beat 1, then a valid config packet
        drive_beat(make_hdr(CTRL_PORT, MOD_ID, 4'h9), 1'b0);
        drive_beat(e1, 1'b1);
        idle_cycles(2);
        check("t3_err", {248'h0, cfg_err_cnt}, {248'h0, 16'd1});
        check("t3_no_write", wr_pulses, 1);
        send_cfg(4'h9, e1, 4'h7);
        idle_cycles(3);
        check("t3_mem9", {4'h0, mem[9]}, {4'h0, 4'h7, e1});
        check("t3_wr_cnt", {248'h0, cfg_wr_cnt}, {248'h0, 16'd2});

        // 4: 5-beat hit packet with downstream stalled
        m_axis_tready = 1'b0;
        stall_cycles = 0;
        drive_beat(make_hdr(CTRL_PORT, MOD_ID, 4'h2), 1'b0);
        for (int i = 0; i < 4; i++) drive_beat(e2, (i == 3) ? 1'b1 : 1'b0);
        idle_cycles(1);
        check("t4_mid_err", {248'h0, cfg_err_cnt}, {248'h0, 16'd2});
        m_axis_tready = 1'b1;
        idle_cycles(2);
        check("t4_no_stall", stall_cycles, 0);
        check("t4_no_write", wr_pulses, 2);
        check("t4_mem2", {4'h0, mem[2]}, 264'h0);
        check("t4_state_idle", {261'h0, state_dbg}, 264'h0);

        // 5: back-to-back config packets to addr 3
        wr_cyc_q.delete();
        send_cfg(4'h3, e1, 4'h1);
        send_cfg(4'h3, e2, 4'h2);
        idle_cycles(3);
        check("t5_pulses", wr_pulses, 4);
        if (wr_cyc_q.size() == 2) check("t5_spacing", wr_cyc_q[1] - wr_cyc_q[0], 4);
        else check("t5_wr_hist", wr_cyc_q.size(), 2);
        check("t5_mem3", {4'h0, mem[3]}, {4'h0, 4'h2, e2});
        check("t5_wr_cnt", {248'h0, cfg_wr_cnt}, {248'h0, 16'd4});

        // 6: reset while in CFG_D2
        drive_beat(make_hdr(CTRL_PORT, MOD_ID, 4'h6), 1'b0);
        drive_beat(e1, 1'b0);
        check("t6_in_d2", {261'h0, state_dbg}, {261'h0, 3'd3});
        wr_before = wr_pulses;
        s_axis_tdata  = {252'h0, 4'hF};
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        #1;
        aresetn = 1'b0;
        #1;
        check("t6_rst_tready", {263'h0, s_axis_tready}, 264'h0);
        check("t6_rst_tvalid", {263'h0, m_axis_tvalid}, 264'h0);
        check("t6_rst_cnts", {232'h0, cfg_wr_cnt, cfg_err_cnt}, 264'h0);
        check("t6_rst_ram", {3'h0, ram_ena, ram_addra, ram_dina}, 264'h0);
        check("t6_rst_state", {261'h0, state_dbg}, 264'h0);
        idle_cycles(2);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        aresetn = 1'b1;
        idle_cycles(2);
        check("t6_no_write", wr_pulses, wr_before);
        send_cfg(4'hA, e2, 4'h5);
        idle_cycles(3);
        check("t6_memA", {4'h0, mem[10]}, {4'h0, 4'h5, e2});
        check("t6_mem6", {4'h0, mem[6]}, 264'h0);
        check("t6_wr_cnt", {248'h0, cfg_wr_cnt}, {248'h0, 16'd1});
        check("t6_err_cnt", {248'h0, cfg_err_cnt}, 264'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global run bound
    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
